// File: rtl/riscv_irq_scheduler.sv
// riscv_irq_scheduler: interrupt front-end for the core.
// Latches level/edge interrupt sources and applies the CSR mask. It presents
// one interrupt at a time, chosen by fixed priority (lowest index wins), as a
// one-hot line. It then blocks further delivery until the handler returns.
//
// Ports:
//   clk           core clock
//   rst           asynchronous active-high reset
//   irq_src_i     raw interrupt sources (synchronous to clk)
//   irq_mask_i    per-source enable from CSR (1 = enabled)
//   irq_enable_i  global interrupt enable from CSR
//   irq_taken_i   exception controller accepted the presented interrupt
//   eret_i        handler return executed
//   irq_o         one-hot interrupt line to the exception controller
//   irq_id_o      index of the presented / in-service interrupt
//   busy_o        an interrupt is in service
//   pending_o     pending register for CSR readback
module riscv_irq_scheduler #(
  parameter int unsigned N_IRQ     = 32,
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             irq_enable_i,
  input  logic             irq_taken_i,
  input  logic             eret_i,
  output logic [31:0]      irq_o,
  output logic [4:0]       irq_id_o,
  output logic             busy_o,
  output logic [N_IRQ-1:0] pending_o
);

  localparam int unsigned ID_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESENT    = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] cand;
  logic [ID_W-1:0]  sel_id_q, sel_id_d;
  logic [ID_W-1:0]  low_id;
  logic             found;
  logic             take_clr;
  logic [31:0]      irq_d;
  logic             busy_d;

  assign cand = pending_q & irq_mask_i;

  // Fixed-priority pick: scan downward so the lowest set index is kept last.
  always_comb begin
    low_id = '0;
    found  = 1'b0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        low_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    sel_id_d = sel_id_q;
    take_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_enable_i && found) begin
          sel_id_d = low_id;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        // The line is never withdrawn once presented, only taken.
        if (irq_taken_i) begin
          take_clr = 1'b1;
          state_d  = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        if (eret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_d  = (state_d == PRESENT) ? (32'd1 << sel_id_d) : 32'd0;
    busy_d = (state_d == IN_SERVICE);
  end

  // Pending update: level bits follow the source. An edge bit sets on a
  // rising edge and clears only on take; a new edge in the take cycle wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = (irq_src_i[i] & ~src_q[i]) |
                       (pending_q[i] & ~(take_clr && (sel_id_q == ID_W'(i))));
      end else begin
        pending_d[i] = irq_src_i[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_id_q  <= '0;
      pending_q <= '0;
      src_q     <= '0;
      irq_o     <= '0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_id_q  <= sel_id_d;
      pending_q <= pending_d;
      src_q     <= irq_src_i;
      irq_o     <= irq_d;
      busy_o    <= busy_d;
    end
  end

  assign irq_id_o  = sel_id_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_riscv_irq_scheduler.sv
// Directed testbench for riscv_irq_scheduler (source 5 edge-triggered).
module tb_riscv_irq_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_src;
  logic [31:0] irq_mask;
  logic        irq_enable;
  logic        irq_taken;
  logic        eret;
  logic [31:0] irq;
  logic [4:0]  irq_id;
  logic        busy;
  logic [31:0] pending;

  int n_checks = 0;
  int n_fails  = 0;

  riscv_irq_scheduler #(
    .N_IRQ    (32),
    .EDGE_MASK(32'h0000_0020)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src_i   (irq_src),
    .irq_mask_i  (irq_mask),
    .irq_enable_i(irq_enable),
    .irq_taken_i (irq_taken),
    .eret_i      (eret),
    .irq_o       (irq),
    .irq_id_o    (irq_id),
    .busy_o      (busy),
    .pending_o   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    irq_src    = '0;
    irq_mask   = 32'hFFFF_FFFF;
    irq_enable = 1'b1;
    irq_taken  = 1'b0;
    eret       = 1'b0;
    #1;
    chk("rst_irq", irq, 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pend", pending, 32'h0);
    #20;
    rst = 1'b0;
    tick();
    tick();

    // Level source 3: pending next cycle, presented the cycle after.
    irq_src = 32'h8;
    tick();
    chk("l3_pend", pending, 32'h8);
    chk("l3_irq_early", irq, 32'h0);
    tick();
    chk("l3_irq", irq, 32'h8);
    chk("l3_id", 32'(irq_id), 32'd3);
    tick();
    tick();
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    chk("l3_take_irq", irq, 32'h0);
    chk("l3_take_busy", 32'(busy), 32'h1);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    chk("l3_taken_ignored", 32'(busy), 32'h1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("l3_eret_busy", 32'(busy), 32'h0);
    chk("l3_eret_irq", irq, 32'h0);
    chk("l3_id_hold", 32'(irq_id), 32'd3);
    tick();
    chk("l3_represent", irq, 32'h8);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    irq_src = '0;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("l3_done", irq, 32'h0);

    // Sources 7 and 2 together: 2 wins, 7 follows after eret.
    irq_src = 32'h84;
    tick();
    chk("pri_pend", pending, 32'h84);
    tick();
    chk("pri_first", irq, 32'h4);
    chk("pri_first_id", 32'(irq_id), 32'd2);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    irq_src = 32'h80;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("pri_second", irq, 32'h80);
    chk("pri_second_id", 32'(irq_id), 32'd7);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    irq_src = '0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("pri_done", irq, 32'h0);

    // Edge source 5: one-cycle pulse stays pending until take.
    irq_src = 32'h20;
    tick();
    irq_src = '0;
    chk("e5_pend", pending, 32'h20);
    tick();
    chk("e5_irq", irq, 32'h20);
    tick();
    chk("e5_pend_hold", pending, 32'h20);
    irq_taken = 1'b1;
    irq_src = 32'h20;
    tick();
    irq_taken = 1'b0;
    irq_src = '0;
    chk("e5_edge_wins", pending, 32'h20);
    chk("e5_busy", 32'(busy), 32'h1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("e5_represent", irq, 32'h20);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    chk("e5_take_clears", pending, 32'h0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("e5_done", irq, 32'h0);

    // Level source 1: line held after source, mask and enable drop.
    irq_src = 32'h2;
    tick();
    tick();
    chk("l1_irq", irq, 32'h2);
    irq_src = '0;
    irq_mask = 32'hFFFF_FFFD;
    irq_enable = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("l1_hold", irq, 32'h2);
    chk("l1_pend_gone", pending, 32'h0);
    tick();
    chk("l1_hold2", irq, 32'h2);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    chk("l1_taken", irq, 32'h0);
    irq_mask = 32'hFFFF_FFFF;
    irq_enable = 1'b1;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    chk("l1_done", irq, 32'h0);

    // Global enable gates presentation but not pending.
    irq_enable = 1'b0;
    irq_src = 32'h10;
    tick();
    tick();
    tick();
    chk("en_off_irq", irq, 32'h0);
    chk("en_off_pend", pending, 32'h10);
    irq_enable = 1'b1;
    tick();
    chk("en_on_irq", irq, 32'h10);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    chk("en_busy", 32'(busy), 32'h1);

    // Asynchronous reset mid-service.
    #2;
    rst = 1'b1;
    irq_src = '0;
    #1;
    chk("arst_irq", irq, 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_id", 32'(irq_id), 32'h0);
    chk("arst_pend", pending, 32'h0);
    #3;
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_irq", irq, 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/riscv_irq_scheduler.md
Name: riscv_irq_scheduler

Overview:
- Interrupt front-end for the core. Latches level- and edge-triggered interrupt sources and applies the CSR mask.
- Selects one interrupt at a time by fixed priority (lowest index wins) and presents it as a single one-hot line on the exception controller's 32-bit irq input.
- Holds that line until the core takes it, then blocks further interrupts until the handler returns (eret). This enforces non-nested, one-at-a-time interrupt delivery.

Parameters:
- N_IRQ, 32, number of interrupt sources (1..32).
- EDGE_MASK, 32'h0000_0000, bit i=1: source i is rising-edge triggered; bit i=0: level-triggered.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- irq_src_i  input  N_IRQ  raw interrupt sources, synchronous to clk.
- irq_mask_i  input  N_IRQ  per-source enable from CSR (1 = enabled).
- irq_enable_i  input  1  global interrupt enable from CSR.
- irq_taken_i  input  1  exception controller accepted an interrupt this cycle (save_cause with cause[5]=1).
- eret_i  input  1  handler return executed.
- irq_o  output  32  one-hot interrupt to the exception controller; bits >= N_IRQ are tied 0.
- irq_id_o  output  5  index of presented or in-service interrupt.
- busy_o  output  1  interrupt in service.
- pending_o  output  N_IRQ  pending register, for CSR readback.

Behaviour:
- Reset (async, rst=1):
  - pending=0, state=IDLE, sel_id=0.
  - irq_o=0, irq_id_o=0, busy_o=0, pending_o=0.
- Pending register, updated every cycle in all states:
  - Level source i: pending[i] <= irq_src_i[i].
  - Edge source i: pending[i] <= 1 on a rising edge (src_q[i]=0 and src[i]=1).
  - Edge source i clears only on take of index i. A new edge on the same cycle as the take wins, so the bit stays set.
  - src_q resets to 0. A source held high through reset therefore produces one edge on the first cycle after reset.
- Candidate set: cand = pending & irq_mask_i.
- FSM states:
  - IDLE:
    - irq_o=0, busy_o=0.
    - If irq_enable_i and |cand: sel_id <= lowest set index of cand; go to PRESENT.
  - PRESENT:
    - irq_o = one-hot(sel_id), registered, stable for the whole state.
    - The line is held even if its pending bit, mask or irq_enable_i drops. No withdrawal once presented; the handler must tolerate a stale cause.
    - On irq_taken_i: clear pending[sel_id] if it is an edge source; go to IN_SERVICE.
  - IN_SERVICE:
    - irq_o=0, busy_o=1.
    - irq_taken_i is ignored.
    - On eret_i: go to IDLE.
  - eret_i is ignored in IDLE and PRESENT.
- Outputs:
  - irq_o and busy_o are registered, derived from the next state.
  - irq_id_o = sel_id, valid in PRESENT and IN_SERVICE; it holds its last value in IDLE.
- Latency:
  - Edge or level assertion at cycle n → pending at n+1 → irq_o at n+2 (given IDLE and enabled).
  - Take at cycle t → irq_o=0 and busy_o=1 at t+1.
  - eret at cycle e → IDLE at e+1 → next irq_o no earlier than e+2.
- Priority: among simultaneous candidates, the lowest index is presented. Higher-index candidates stay pending and are re-arbitrated after eret. There is no preemption.
- Taken in the same cycle as entering PRESENT cannot occur, because irq_o is not yet visible.

Test Plan:
- Level source 3 asserted at cycle 10, masked in, enable=1 → pending_o[3]=1 at 11; irq_o=32'h8 and irq_id_o=3 at 12. taken at 14 → irq_o=0 and busy_o=1 at 15. eret at 20 → busy_o=0 at 21; source 3 still high → irq_o=32'h8 again at 22.
- Sources 7 and 2 asserted in the same cycle → irq_o=32'h4 first. After take + eret → irq_o=32'h80.
- Edge source 5 (EDGE_MASK bit 5 set), pulse 1 cycle → pending[5] stays set until take. A second pulse in the take cycle → pending[5] remains 1 → re-presented after eret.
- Level source 1 presented, then the source drops and mask clears before take → irq_o stays 32'h2 until taken_i; no glitch to 0.
- irq_enable_i=0 with source 4 pending → irq_o=0, pending_o[4]=1. Enable raised at cycle k → irq_o=32'h10 at k+1.
- rst asserted mid-IN_SERVICE → all outputs 0 immediately (async). After release with sources low → FSM in IDLE, irq_o=0.
